// File: rtl/serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding, nibble width, counter sizing.
`timescale 1ns/1ps
package serial_adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } sna_state_e;

  // Beat counter width; a single-beat adder still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/adder_4bit.sv
// Combinational 4-bit adder with carry-in and carry-out; the per-beat datapath.
`timescale 1ns/1ps
module adder_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] s_o,
  output logic       c4_o
);

  assign {c4_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};

endmodule

// File: rtl/serial_nibble_adder.sv
// WIDTH-bit adder computed one nibble per clock through a single adder_4bit.
// Define SNA_OVERFLOW_EN to add the registered signed-overflow output ovf.
`timescale 1ns/1ps
module serial_nibble_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SNA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NIB  = WIDTH / NIBBLE_W;
  localparam int unsigned CntW = cnt_width(NIB);
  localparam logic [CntW-1:0] LastCnt = CntW'(NIB - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
    $error("serial_nibble_adder: WIDTH must be a non-zero multiple of 4");
  end

  sna_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [NIBBLE_W-1:0] nib_s;
  logic             nib_c4;
`ifdef SNA_OVERFLOW_EN
  logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d, ovf_q, ovf_d;
`endif

  adder_4bit u_adder (
    .a_i  (a_sh_q[NIBBLE_W-1:0]),
    .b_i  (b_sh_q[NIBBLE_W-1:0]),
    .cin_i(carry_q),
    .s_o  (nib_s),
    .c4_o (nib_c4)
  );

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef SNA_OVERFLOW_EN
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    ovf_d       = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready_q) begin
          a_sh_d     = a;
          b_sh_d     = b;
          carry_d    = cin;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = StRun;
`ifdef SNA_OVERFLOW_EN
          a_msb_d    = a[WIDTH-1];
          b_msb_d    = b[WIDTH-1];
`endif
        end
      end
      StRun: begin
        // New nibble enters at the top so the result is aligned after NIB beats.
        sum_d   = WIDTH'({nib_s, sum_q} >> NIBBLE_W);
        a_sh_d  = a_sh_q >> NIBBLE_W;
        b_sh_d  = b_sh_q >> NIBBLE_W;
        carry_d = nib_c4;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          cout_d      = nib_c4;
          out_valid_d = 1'b1;
          state_d     = StDone;
`ifdef SNA_OVERFLOW_EN
          ovf_d       = (a_msb_q == b_msb_q) && (nib_s[NIBBLE_W-1] != a_msb_q);
`endif
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = StIdle;
`ifdef SNA_OVERFLOW_EN
          ovf_d       = 1'b0;
`endif
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SNA_OVERFLOW_EN
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef SNA_OVERFLOW_EN
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SNA_OVERFLOW_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Bench for serial_nibble_adder at WIDTH 16 (directed), 4 and 32 (random vs arithmetic model).
`timescale 1ns/1ps
module tb_serial_nibble_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        iv16, ir16, ov16, or16, cin16, cout16;
  logic [15:0] a16, b16, sum16;
  logic        iv4, ir4, ov4, or4, cin4, cout4;
  logic [3:0]  a4, b4, sum4;
  logic        iv32, ir32, ov32, or32, cin32, cout32;
  logic [31:0] a32, b32, sum32;
`ifdef SNA_OVERFLOW_EN
  logic        ovf16, ovf4, ovf32;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  serial_nibble_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin16), .out_valid(ov16), .out_ready(or16), .sum(sum16), .cout(cout16)
`ifdef SNA_OVERFLOW_EN
    , .ovf(ovf16)
`endif
  );

  serial_nibble_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .cin(cin4), .out_valid(ov4), .out_ready(or4), .sum(sum4), .cout(cout4)
`ifdef SNA_OVERFLOW_EN
    , .ovf(ovf4)
`endif
  );

  serial_nibble_adder #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .cin(cin32), .out_valid(ov32), .out_ready(or32), .sum(sum32), .cout(cout32)
`ifdef SNA_OVERFLOW_EN
    , .ovf(ovf32)
`endif
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present one operand set on the 16-bit DUT; returns edges from accept to out_valid.
  task automatic op16(input logic [15:0] ta, input logic [15:0] tb2, input logic tc,
                      output int lat);
    a16 = ta; b16 = tb2; cin16 = tc; iv16 = 1'b1; or16 = 1'b0;
    @(posedge clk); #1;
    iv16 = 1'b0;
    lat = 0;
    while (!ov16 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release16();
    or16 = 1'b1;
    @(posedge clk); #1;
    or16 = 1'b0;
    chk("handoff_out_valid_drop", 64'(ov16), 64'd0);
    chk("handoff_in_ready", 64'(ir16), 64'd1);
  endtask

  task automatic rand_test(input int sel);
    int nib = (sel == 0) ? 1 : 8;
    int w = nib * 4;
    string sfx = (sel == 0) ? "4" : "32";
    longint unsigned mask = (64'd1 << w) - 64'd1;
    longint unsigned q_sum[$];
    bit q_cout[$];
    int q_cyc[$];
    int n_acc = 0, n_del = 0, cyc = 0;
    bit prev_ov = 1'b0;
    logic ir, ov, c;
    longint unsigned s, ra, rb, full, es;
    bit iv, orr, rc, ec;
    while ((n_acc < 1000 || q_sum.size() != 0) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (sel == 0) begin
        ir = ir4; ov = ov4; s = 64'(sum4); c = cout4;
      end else begin
        ir = ir32; ov = ov32; s = 64'(sum32); c = cout32;
      end
      if (ov && !prev_ov) begin
        if (q_cyc.size() == 0) chk({"rand", sfx, "_spurious_valid"}, 64'd1, 64'd0);
        else chk({"rand", sfx, "_latency"}, 64'(cyc - q_cyc.pop_front()), 64'(nib + 1));
      end
      prev_ov = ov;
      iv  = (n_acc < 1000) && ($urandom_range(0, 1) == 1);
      orr = ($urandom_range(0, 3) != 0);
      ra  = {$urandom, $urandom} & mask;
      rb  = {$urandom, $urandom} & mask;
      rc  = 1'($urandom_range(0, 1));
      if (sel == 0) begin
        iv4 = iv; or4 = orr; a4 = ra[3:0]; b4 = rb[3:0]; cin4 = rc;
      end else begin
        iv32 = iv; or32 = orr; a32 = ra[31:0]; b32 = rb[31:0]; cin32 = rc;
      end
      if (iv && ir) begin
        full = ra + rb + 64'(rc);
        q_sum.push_back(full & mask);
        q_cout.push_back(1'((full >> w) & 64'd1));
        q_cyc.push_back(cyc);
        n_acc++;
      end
      if (ov && orr) begin
        if (q_sum.size() == 0) begin
          chk({"rand", sfx, "_duplicate"}, 64'd1, 64'd0);
        end else begin
          es = q_sum.pop_front();
          ec = q_cout.pop_front();
          chk({"rand", sfx, "_sum"}, s, es);
          chk({"rand", sfx, "_cout"}, 64'(c), 64'(ec));
          n_del++;
        end
      end
    end
    chk({"rand", sfx, "_budget"}, 64'(cyc >= 60000), 64'd0);
    chk({"rand", sfx, "_all_delivered"}, 64'(n_del), 64'd1000);
    if (sel == 0) begin iv4 = 1'b0; or4 = 1'b0; end
    else begin iv32 = 1'b0; or32 = 1'b0; end
  endtask

  initial begin
    int lat;
    bit seen;
    rst_n = 1'b0;
    iv16 = 0; or16 = 0; a16 = 0; b16 = 0; cin16 = 0;
    iv4 = 0; or4 = 0; a4 = 0; b4 = 0; cin4 = 0;
    iv32 = 0; or32 = 0; a32 = 0; b32 = 0; cin32 = 0;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[8] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(ir16), 64'd1);
    chk("reset_out_valid", 64'(ov16), 64'd0);
    chk("reset_sum", 64'(sum16), 64'd0);
    chk("reset_cout", 64'(cout16), 64'd0);
`ifdef SNA_OVERFLOW_EN
    chk("reset_ovf", 64'(ovf16), 64'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      op16(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
      chk("vec_latency", 64'(lat), 64'd4);
      chk("vec_sum", 64'(sum16), 64'(vecs[i].sum));
      chk("vec_cout", 64'(cout16), 64'(vecs[i].cout));
`ifdef SNA_OVERFLOW_EN
      chk("vec_ovf", 64'(ovf16), 64'(vecs[i].ovf));
`endif
      release16();
    end

    // Backpressure: result must hold and new operands must be ignored.
    op16(16'h1234, 16'h4321, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      iv16 = 1'b1;
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      @(posedge clk); #1;
      chk("bp_sum", 64'(sum16), 64'h5555);
      chk("bp_cout", 64'(cout16), 64'd0);
      chk("bp_out_valid", 64'(ov16), 64'd1);
      chk("bp_in_ready", 64'(ir16), 64'd0);
    end
    iv16 = 1'b0;
    release16();
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ov16) seen = 1'b1;
    end
    chk("bp_no_ghost_result", 64'(seen), 64'd0);
    chk("bp_sum_held", 64'(sum16), 64'h5555);

    // Asynchronous reset during the second RUN beat.
    a16 = 16'hABCD; b16 = 16'h1111; cin16 = 1'b1; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_sum", 64'(sum16), 64'd0);
    chk("rst_cout", 64'(cout16), 64'd0);
    chk("rst_out_valid", 64'(ov16), 64'd0);
    chk("rst_in_ready", 64'(ir16), 64'd1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (ov16) seen = 1'b1;
    end
    chk("rst_no_out_valid", 64'(seen), 64'd0);
    op16(16'h0F0F, 16'h0101, 1'b0, lat);
    chk("post_rst_latency", 64'(lat), 64'd4);
    chk("post_rst_sum", 64'(sum16), 64'h1010);
    chk("post_rst_cout", 64'(cout16), 64'd0);
    release16();

    rand_test(0);
    rand_test(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
